// File: rtl/mema_read_sequencer.sv
// Matrix-A read sequencer: walks A row-group addresses, pulses read_preprocess per
// group, holds each address while chunks stream, and advances once every module is ready.
module mema_read_sequencer #(
  parameter int          no_of_row_by_vector_modules = 4,
  parameter int          no_of_units                 = 8,
  parameter int          no_of_elements_on_col_nos   = 20,
  parameter int          no_of_row_groups            = 16,
  parameter int unsigned start_address               = 0,
  parameter int          stream_cycles               = 9
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [no_of_row_by_vector_modules-1:0]    I_am_ready,
  output logic [31:0]                               memA_read_address,
  output logic                                      read_preprocess,
  output logic [32*no_of_row_by_vector_modules-1:0] no_of_multiples,
  output logic                                      busy,
  output logic                                      done
);

  localparam int          M           = no_of_row_by_vector_modules;
  localparam logic [31:0] CHUNKS      = 32'((no_of_elements_on_col_nos + no_of_units - 1) / no_of_units);
  localparam logic [31:0] FIRST_ADDR  = 32'(start_address);
  localparam logic [31:0] LAST_ADDR   = 32'(start_address + 32'(no_of_row_groups) - 32'd1);
  localparam logic [31:0] STREAM_LAST = 32'(stream_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREPROC,
    S_STREAM,
    S_WAIT_READY,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [31:0]         r_addr;
  logic [31:0]         w_next_addr;
  logic [31:0]         r_cnt;
  logic [31:0]         w_next_cnt;
  logic                r_read_preprocess;
  logic                r_busy;
  logic                r_done;
  logic [32*M-1:0]     r_multiples;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_PREPROC;
      end
      S_PREPROC: begin
        w_next_cnt   = STREAM_LAST;
        w_next_state = S_STREAM;
      end
      S_STREAM: begin
        if (r_cnt == 32'd0) w_next_state = S_WAIT_READY;
        else                w_next_cnt   = r_cnt - 32'd1;
      end
      S_WAIT_READY: begin
        if (&I_am_ready) w_next_state = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (r_addr == LAST_ADDR) begin
          w_next_state = S_DONE;
        end else begin
          w_next_addr  = r_addr + 32'd1;
          w_next_state = S_PREPROC;
        end
      end
      S_DONE: begin
        w_next_addr  = FIRST_ADDR;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // Flag outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_addr            <= FIRST_ADDR;
      r_cnt             <= 32'd0;
      r_read_preprocess <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_multiples       <= {M{CHUNKS}};
    end else begin
      r_state           <= w_next_state;
      r_addr            <= w_next_addr;
      r_cnt             <= w_next_cnt;
      r_read_preprocess <= (r_state == S_PREPROC);
      r_busy            <= (r_state != S_IDLE);
      r_done            <= (r_state == S_DONE);
      r_multiples       <= r_multiples;
    end
  end

  assign memA_read_address = r_addr;
  assign read_preprocess   = r_read_preprocess;
  assign no_of_multiples   = r_multiples;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_mema_read_sequencer.sv
// Directed self-checking bench for mema_read_sequencer: default instance for the
// full-run scenarios, plus a one-group / short-stream instance for the parameter edge.
module tb_mema_read_sequencer;

  localparam int M = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [M-1:0]    ready = 4'b1111;
  logic [31:0]     memA_read_address;
  logic            read_preprocess;
  logic [32*M-1:0] no_of_multiples;
  logic            busy;
  logic            done;

  logic            start2 = 1'b0;
  logic [M-1:0]    ready2 = 4'b1111;
  logic [31:0]     addr2;
  logic            rp2;
  logic [32*M-1:0] mult2;
  logic            busy2;
  logic            done2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_double = 0;
  logic prev_rp = 1'b0;

  int rp_cyc[$];
  int rp_addr[$];
  int done_cyc[$];
  int rp2_cyc[$];
  int rp2_addr[$];
  int done2_cyc[$];

  always #5 clk = ~clk;

  mema_read_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .I_am_ready        (ready),
    .memA_read_address (memA_read_address),
    .read_preprocess   (read_preprocess),
    .no_of_multiples   (no_of_multiples),
    .busy              (busy),
    .done              (done)
  );

  mema_read_sequencer #(
    .no_of_row_groups (1),
    .start_address    (100),
    .stream_cycles    (2)
  ) dut2 (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start2),
    .I_am_ready        (ready2),
    .memA_read_address (addr2),
    .read_preprocess   (rp2),
    .no_of_multiples   (mult2),
    .busy              (busy2),
    .done              (done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  // Advance one clock, then sample outputs 1 time unit after the edge and log events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (read_preprocess) begin
      rp_cyc.push_back(cyc);
      rp_addr.push_back(int'(memA_read_address));
      if (prev_rp) n_double++;
    end
    prev_rp = read_preprocess;
    if (done) done_cyc.push_back(cyc);
    if (rp2) begin
      rp2_cyc.push_back(cyc);
      rp2_addr.push_back(int'(addr2));
    end
    if (done2) done2_cyc.push_back(cyc);
  endtask

  task automatic clear_logs();
    rp_cyc.delete();
    rp_addr.delete();
    done_cyc.delete();
    rp2_cyc.delete();
    rp2_addr.delete();
    done2_cyc.delete();
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  // Tick until a done pulse or the budget runs out; optional stall on group 3
  // and a stray start pulse during STREAM of group 5.
  task automatic run_until_done(input int budget, input bit do_stall, input bit do_poke);
    int stall_left;
    int n0;
    stall_left = 0;
    n0 = done_cyc.size();
    for (int i = 0; i < budget; i++) begin
      tick();
      if (start) start = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) ready = 4'b1111;
      end
      if (read_preprocess) begin
        if (do_stall && memA_read_address == 32'd3) begin
          ready = 4'b1011;
          stall_left = 16;
        end
        if (do_poke && memA_read_address == 32'd5) start = 1'b1;
      end
      if (done_cyc.size() > n0) break;
    end
  endtask

  task automatic check_full_run(input string pfx, input int t0, input int stall_gap_idx);
    check({pfx, "_rp_count"}, rp_cyc.size(), 16);
    check({pfx, "_first_latency"}, qi(rp_cyc, 0) - t0, 1);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_addr%0d", pfx, i), qi(rp_addr, i), i);
    for (int i = 1; i < 16; i++)
      check($sformatf("%s_gap%0d", pfx, i), qi(rp_cyc, i) - qi(rp_cyc, i - 1),
            (i == stall_gap_idx) ? 19 : 12);
    check({pfx, "_done_count"}, done_cyc.size(), 1);
    check({pfx, "_done_cycle"}, qi(done_cyc, 0) - qi(rp_cyc, 15), 12);
    check({pfx, "_addr_at_done"}, memA_read_address, 0);
    tick();
    check({pfx, "_busy_after"}, busy, 0);
    check({pfx, "_addr_after"}, memA_read_address, 0);
  endtask

  initial begin
    int t0;
    bit bad;
    bit found;

    // Reset, then idle for 20 cycles.
    tick();
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || done || read_preprocess || memA_read_address != 32'd0) bad = 1'b1;
    end
    check("idle_addr", memA_read_address, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_rp", read_preprocess, 0);
    check("idle_quiet", bad, 0);
    for (int m = 0; m < M; m++)
      check($sformatf("multiples%0d", m), no_of_multiples[32*m +: 32], 3);
    check("dut2_reset_addr", addr2, 100);

    // Full run with all modules ready.
    clear_logs();
    pulse_start(t0);
    run_until_done(260, 1'b0, 1'b0);
    check_full_run("run", t0, 0);

    // Stall on group 3 plus a stray start in STREAM of group 5.
    repeat (3) tick();
    clear_logs();
    pulse_start(t0);
    run_until_done(300, 1'b1, 1'b1);
    check_full_run("stall", t0, 4);
    repeat (15) tick();
    check("stray_start_no_rerun", rp_cyc.size(), 16);
    check("stray_start_idle", busy, 0);

    // Reset during WAIT_READY of group 9.
    clear_logs();
    pulse_start(t0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (read_preprocess && memA_read_address == 32'd9) found = 1'b1;
    end
    check("reset_group9_reached", found, 1);
    ready = 4'b0000;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ready = 4'b1111;
    check("midreset_addr", memA_read_address, 0);
    check("midreset_busy", busy, 0);
    check("midreset_rp", read_preprocess, 0);
    repeat (5) tick();
    check("midreset_no_done", done_cyc.size(), 0);
    check("midreset_still_idle", busy, 0);
    clear_logs();
    pulse_start(t0);
    tick();
    check("restart_first_addr", qi(rp_addr, 0), 0);
    check("restart_latency", qi(rp_cyc, 0) - t0, 1);
    run_until_done(260, 1'b0, 1'b0);
    check("restart_done_count", done_cyc.size(), 1);
    check("restart_rp_count", rp_cyc.size(), 16);

    // One row group at address 100 with a 2-cycle stream.
    repeat (3) tick();
    clear_logs();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    t0 = cyc;
    repeat (12) tick();
    check("edge_rp_count", rp2_cyc.size(), 1);
    check("edge_rp_latency", qi(rp2_cyc, 0) - t0, 1);
    check("edge_rp_addr", qi(rp2_addr, 0), 100);
    check("edge_done_count", done2_cyc.size(), 1);
    check("edge_done_latency", qi(done2_cyc, 0) - t0, 6);
    check("edge_addr_after", addr2, 100);
    check("edge_busy_after", busy2, 0);

    check("rp_never_back_to_back", n_double, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
